uart_frame_loader: RTL and testbench

//  Consumes the byte stream from uart_rcvr (uart_data / uart_data_rdy) and assembles one image frame.

---
 rtl/uart_frame_loader.sv | 118 +++++++++++
 tb/tb_uart_frame_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_loader.sv
// uart_frame_loader: assembles a SYNC0/SYNC1-framed, checksummed pixel stream into a frame buffer
// and hands the finished frame to the consumer via frame_valid/frame_ack.
module uart_frame_loader #(
    parameter int         IMG_W        = 40,
    parameter int         IMG_H        = 30,
    parameter logic [7:0] SYNC0        = 8'hA5,
    parameter logic [7:0] SYNC1        = 8'h5A,
    parameter int         TIMEOUT_CLKS = 16384,
    localparam int        NPIX         = IMG_W * IMG_H,
    localparam int        ADDR_W       = $clog2(NPIX)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              uart_data_rdy,
    input  logic [7:0]        uart_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_valid,
    input  logic              frame_ack,
    output logic              frame_err,
    output logic              busy
);
    localparam int TMO_W = $clog2(TIMEOUT_CLKS);

    typedef enum logic [2:0] {S_IDLE, S_SYNC1, S_PIXELS, S_CSUM, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              rdy_q;
    logic [ADDR_W-1:0] cnt_q, cnt_d, wr_addr_q, wr_addr_d;
    logic [7:0]        sum_q, sum_d, wr_data_q, wr_data_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              wr_en_q, wr_en_d, frame_err_q, frame_err_d;
    logic              frame_valid_q, busy_q;
    logic              byte_evt, in_frame, expire;

    always_comb begin
        byte_evt    = uart_data_rdy & ~rdy_q;
        in_frame    = state_q inside {S_SYNC1, S_PIXELS, S_CSUM};
        expire      = in_frame & ~byte_evt & (tmo_q == TMO_W'(TIMEOUT_CLKS - 1));
        state_d     = state_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        // Counter runs only inside a frame; any byte (and thus any state entry) clears it.
        tmo_d       = (in_frame & ~byte_evt & ~expire) ? tmo_q + 1'b1 : '0;
        case (state_q)
            S_IDLE:
                if (byte_evt && uart_data == SYNC0) state_d = S_SYNC1;
            S_SYNC1: begin
                cnt_d = '0;
                sum_d = '0;
                if (byte_evt)
                    state_d = (uart_data == SYNC1) ? S_PIXELS :
                              (uart_data == SYNC0) ? S_SYNC1 : S_IDLE;
            end
            S_PIXELS:
                if (byte_evt) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = uart_data;
                    sum_d     = sum_q + uart_data;
                    if (cnt_q == ADDR_W'(NPIX - 1)) state_d = S_CSUM;
                    else cnt_d = cnt_q + 1'b1;
                end
            S_CSUM:
                if (byte_evt) begin
                    state_d     = (uart_data == sum_q) ? S_DONE : S_IDLE;
                    frame_err_d = (uart_data != sum_q);
                end
            S_DONE:
                if (frame_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (expire) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rdy_q         <= 1'b0;
            cnt_q         <= '0;
            sum_q         <= '0;
            tmo_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_err_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rdy_q         <= uart_data_rdy;
            cnt_q         <= cnt_d;
            sum_q         <= sum_d;
            tmo_q         <= tmo_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_err_q   <= frame_err_d;
            frame_valid_q <= (state_d == S_DONE);
            busy_q        <= state_d inside {S_SYNC1, S_PIXELS, S_CSUM};
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_err   = frame_err_q;
    assign frame_valid = frame_valid_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_uart_frame_loader.sv
// tb_uart_frame_loader: scoreboard bench for uart_frame_loader on a 4x2 image with a 64-clock timeout.
module tb_uart_frame_loader;
    localparam int NPIX = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       uart_data_rdy = 1'b0;
    logic [7:0] uart_data = 8'h00;
    logic       frame_ack = 1'b0;
    logic       wr_en, frame_valid, frame_err, busy;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;

    int          n_tests = 0;
    int          n_fail = 0;
    int          err_cnt = 0;
    logic        err_prev = 1'b0;
    logic [15:0] exp_q[$];
    logic [7:0]  pix[NPIX];

    uart_frame_loader #(.IMG_W(4), .IMG_H(2), .TIMEOUT_CLKS(64)) dut (
        .clock(clock), .reset(reset), .uart_data_rdy(uart_data_rdy), .uart_data(uart_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_valid(frame_valid),
        .frame_ack(frame_ack), .frame_err(frame_err), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (wr_en) begin
                if (exp_q.size() == 0) check("wr_spurious", 32'(wr_en), 32'd0);
                else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(e[15:8]));
                    check("wr_data", 32'(wr_data), 32'(e[7:0]));
                end
            end
            if (frame_err) begin
                err_cnt++;
                check("err_one_cycle", 32'(err_prev), 32'd0);
            end
            err_prev = frame_err;
        end else err_prev = 1'b0;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        uart_data     = b;
        uart_data_rdy = 1'b1;
        @(negedge clock);
        uart_data_rdy = 1'b0;
        @(negedge clock);
    endtask

    task automatic send_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({8'(i), pix[i]});
            send_byte(pix[i]);
        end
    endtask

    task automatic send_frame(input logic [7:0] cs);
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_pixels(NPIX);
        send_byte(cs);
        repeat (2) @(negedge clock);
    endtask

    task automatic ack_frame(input string tag);
        frame_ack = 1'b1;
        @(negedge clock);
        frame_ack = 1'b0;
        check({tag, "_valid_after_ack"}, 32'(frame_valid), 32'd0);
    endtask

    function automatic logic [7:0] pix_sum();
        logic [7:0] s = 8'h00;
        for (int i = 0; i < NPIX; i++) s += pix[i];
        return s;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs, waited;
        repeat (3) @(negedge clock);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(wr_addr), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // good frame 01..08, checksum 24
        for (int i = 0; i < NPIX; i++) pix[i] = 8'(i + 1);
        send_frame(8'h24);
        check("t1_valid", 32'(frame_valid), 32'd1);
        check("t1_err", 32'(err_cnt), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        ack_frame("t1");

        // bad checksum
        errs = err_cnt;
        send_frame(8'h25);
        check("t2_err", 32'(err_cnt - errs), 32'd1);
        check("t2_valid", 32'(frame_valid), 32'd0);
        check("t2_busy", 32'(busy), 32'd0);

        // resync on junk then repeated SYNC0
        send_byte(8'h33);
        send_byte(8'hA5);
        check("t3_busy_sync1", 32'(busy), 32'd1);
        for (int i = 0; i < NPIX; i++) pix[i] = 8'h10;
        send_frame(8'h80);
        check("t3_valid", 32'(frame_valid), 32'd1);
        ack_frame("t3");

        // timeout after two pixels
        errs = err_cnt;
        pix[0] = 8'h01;
        pix[1] = 8'h02;
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_pixels(2);
        waited = 0;
        while (err_cnt == errs && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        check("t4_err", 32'(err_cnt - errs), 32'd1);
        check("t4_tmo_window", 32'(waited >= 55 && waited <= 70), 32'd1);
        @(negedge clock);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_valid", 32'(frame_valid), 32'd0);
        for (int i = 0; i < NPIX; i++) pix[i] = 8'(8'h11 * (i + 1));
        send_frame(pix_sum());
        check("t4_valid_next", 32'(frame_valid), 32'd1);

        // bytes and held rdy while DONE are dropped
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_byte(8'h77);
        @(negedge clock);
        uart_data     = 8'h42;
        uart_data_rdy = 1'b1;
        repeat (3) @(negedge clock);
        uart_data_rdy = 1'b0;
        repeat (2) @(negedge clock);
        check("t5_valid", 32'(frame_valid), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        ack_frame("t5");

        // reset mid-frame
        for (int i = 0; i < NPIX; i++) pix[i] = 8'(8'hF0 + i * 3);
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_pixels(4);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("t6_wr_en", 32'(wr_en), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_valid", 32'(frame_valid), 32'd0);
        check("t6_addr", 32'(wr_addr), 32'd0);
        check("t6_data", 32'(wr_data), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        send_frame(pix_sum());
        check("t6_valid_next", 32'(frame_valid), 32'd1);
        ack_frame("t6");

        repeat (3) @(negedge clock);
        check("writes_pending", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
